// File: rtl/datapath_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared arithmetic datapath.
// Ports: clk, rst_n; req{0,1}_{valid,ready,a,b,opcode}; rsp_{valid,ready,id,y,co}; ops_done.

// datapath: combinational ALU, A/B/opcode in, Y/co out.
// 0 add, 1 sub (co=borrow), 2 and, 3 or, 4 xor, 5 shl1, 6 sar1, 7 pass A.
module datapath #(
   parameter int N = 16
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   opcode,
   output logic [N-1:0] Y,
   output logic         co
);

   always_comb begin
      {co, Y} = '0;
      unique case (opcode)
         3'd0: {co, Y} = {1'b0, A} + {1'b0, B};
         3'd1: {co, Y} = {1'b0, A} - {1'b0, B};
         3'd2: Y = A & B;
         3'd3: Y = A | B;
         3'd4: Y = A ^ B;
         3'd5: {co, Y} = {A, 1'b0};
         3'd6: begin
            Y  = {A[N-1], A[N-1:1]};
            co = A[0];
         end
         3'd7: Y = A;
      endcase
   end

endmodule

module datapath_arbiter #(
   parameter int N     = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [N-1:0]     req0_a,
   input  logic [N-1:0]     req0_b,
   input  logic [2:0]       req0_opcode,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [N-1:0]     req1_a,
   input  logic [N-1:0]     req1_b,
   input  logic [2:0]       req1_opcode,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [N-1:0]     rsp_y,
   output logic             rsp_co,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t         state, state_nx;
   logic           last_grant;
   logic           win;
   logic           acc;
   logic [N-1:0]   op_a, op_b, dp_y;
   logic [2:0]     op_code;
   logic           op_id, dp_co;

   datapath #(.N(N)) u_dp (
      .A      (op_a),
      .B      (op_b),
      .opcode (op_code),
      .Y      (dp_y),
      .co     (dp_co)
   );

   // On a tie the requester not granted last time wins.
   always_comb begin
      win = req1_valid;
      if (req0_valid && req1_valid) win = ~last_grant;
      req0_ready = rst_n && (state == IDLE) && req0_valid && !win;
      req1_ready = rst_n && (state == IDLE) && req1_valid && win;
      acc = req0_ready | req1_ready;
      state_nx = state;
      unique case (state)
         IDLE: if (acc) state_nx = EXEC;
         EXEC: state_nx = HOLD;
         HOLD: if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         op_code    <= '0;
         op_id      <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_y      <= '0;
         rsp_co     <= 1'b0;
         ops_done   <= '0;
      end else begin
         if (acc) begin
            last_grant <= win;
            op_id      <= win;
            op_a       <= win ? req1_a : req0_a;
            op_b       <= win ? req1_b : req0_b;
            op_code    <= win ? req1_opcode : req0_opcode;
         end
         if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_y     <= dp_y;
            rsp_co    <= dp_co;
         end
         if (state == HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
            if (ops_done != '1) ops_done <= ops_done + CNT_W'(1);
         end
      end
   end

endmodule
